// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, load/store sequencer state encoding,
// and the default vector lane count.
// Imported by the LSU sequencer and its lane priority encoder.
package cpu_types_pkg;

  localparam int THREADS_DEF = 4;
  localparam int WORD_W_DEF  = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    SDATA,
    VDATA,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lane_priority_enc.sv
// Lane priority encoder: finds the next set lane in a vector mask.
// Ports: mask (active lanes), cur (current lane), from_start (search from lane 0
// inclusive instead of strictly above cur) -> next_idx (found lane), none (no lane left).
module lane_priority_enc #(
  parameter int THREADS = cpu_types_pkg::THREADS_DEF,
  parameter int IDX_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic [THREADS-1:0] mask,
  input  logic [IDX_W-1:0]   cur,
  input  logic               from_start,
  output logic [IDX_W-1:0]   next_idx,
  output logic               none
);

  // Ascending scan; the first qualifying lane wins, so the result is the
  // lowest set lane at or after the search start.
  always_comb begin
    next_idx = '0;
    none     = 1'b1;
    for (int i = 0; i < THREADS; i++) begin
      if (none && mask[i] && (from_start || (IDX_W'(i) > cur))) begin
        next_idx = IDX_W'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: serialises instruction fetch, scalar and per-lane vector
// data accesses onto one shared cache port (cREN/cWEN/cAddr/cStore, cLoad/cWait).
// Ports: instReq/iaddr -> iload/iHit; readReq/writeReq/isVector/laneMask with
// scalar (sdaddr/sdstore) and vector (vdaddr/vdstore) operands -> sdload/vdload/dHit;
// dhalt blocks new acceptance. Data requests win over fetch in the same cycle.
module lsu_sequencer
  import cpu_types_pkg::*;
#(
  parameter int THREADS = THREADS_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           instReq,
  input  logic [WORD_W-1:0]              iaddr,
  output logic [WORD_W-1:0]              iload,
  output logic                           iHit,
  input  logic                           readReq,
  input  logic                           writeReq,
  input  logic                           isVector,
  input  logic [THREADS-1:0]             laneMask,
  input  logic [WORD_W-1:0]              sdaddr,
  input  logic [WORD_W-1:0]              sdstore,
  input  logic [THREADS-1:0][WORD_W-1:0] vdaddr,
  input  logic [THREADS-1:0][WORD_W-1:0] vdstore,
  output logic [WORD_W-1:0]              sdload,
  output logic [THREADS-1:0][WORD_W-1:0] vdload,
  output logic                           dHit,
  input  logic                           dhalt,
  output logic                           cREN,
  output logic                           cWEN,
  output logic [WORD_W-1:0]              cAddr,
  output logic [WORD_W-1:0]              cStore,
  input  logic [WORD_W-1:0]              cLoad,
  input  logic                           cWait
);

  localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

  lsu_state_t                     state, state_n;
  logic [IDX_W-1:0]               lane_idx, first_idx, next_idx;
  logic                           first_none, next_none;
  logic                           lat_write;
  logic [THREADS-1:0]             lat_mask;
  logic [WORD_W-1:0]              lat_iaddr, lat_saddr, lat_sstore;
  logic [THREADS-1:0][WORD_W-1:0] lat_vaddr, lat_vstore;
  logic                           data_req, acc_data, acc_fetch, xfer_done;

  assign data_req  = readReq | writeReq;
  assign acc_data  = (state == IDLE) && !dhalt && data_req;
  assign acc_fetch = (state == IDLE) && !dhalt && !data_req && instReq;
  assign xfer_done = (cREN | cWEN) & ~cWait;

  // First lane comes straight from the incoming mask at acceptance.
  lane_priority_enc #(.THREADS(THREADS), .IDX_W(IDX_W)) u_enc_first (
    .mask       (laneMask),
    .cur        ('0),
    .from_start (1'b1),
    .next_idx   (first_idx),
    .none       (first_none)
  );

  // Following lanes come from the latched mask, strictly above the current lane.
  lane_priority_enc #(.THREADS(THREADS), .IDX_W(IDX_W)) u_enc_next (
    .mask       (lat_mask),
    .cur        (lane_idx),
    .from_start (1'b0),
    .next_idx   (next_idx),
    .none       (next_none)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Cache port is a pure decode of state and latched operands, so the
  // strobes drop in the same cycle that reset asserts.
  always_comb begin
    state_n = state;
    cREN    = 1'b0;
    cWEN    = 1'b0;
    cAddr   = '0;
    cStore  = '0;
    dHit    = 1'b0;
    case (state)
      IDLE: begin
        if (acc_data) begin
          if (!isVector)      state_n = SDATA;
          else if (first_none) state_n = DONE;
          else                state_n = VDATA;
        end else if (acc_fetch) begin
          state_n = IFETCH;
        end
      end
      IFETCH: begin
        cREN  = 1'b1;
        cAddr = lat_iaddr;
        if (!cWait) state_n = IDLE;
      end
      SDATA: begin
        cREN   = !lat_write;
        cWEN   = lat_write;
        cAddr  = lat_saddr;
        cStore = lat_sstore;
        if (!cWait) state_n = DONE;
      end
      VDATA: begin
        cREN   = !lat_write;
        cWEN   = lat_write;
        cAddr  = lat_vaddr[lane_idx];
        cStore = lat_vstore[lane_idx];
        if (!cWait && next_none) state_n = DONE;
      end
      DONE: begin
        dHit    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iload      <= '0;
      iHit       <= 1'b0;
      sdload     <= '0;
      vdload     <= '0;
      lane_idx   <= '0;
      lat_write  <= 1'b0;
      lat_mask   <= '0;
      lat_iaddr  <= '0;
      lat_saddr  <= '0;
      lat_sstore <= '0;
      lat_vaddr  <= '0;
      lat_vstore <= '0;
    end else begin
      iHit <= (state == IFETCH) && !cWait;
      if ((state == IFETCH) && !cWait) iload <= cLoad;

      if (acc_data) begin
        // Simultaneous read and write requests resolve to a store.
        lat_write  <= writeReq;
        lat_mask   <= laneMask;
        lat_saddr  <= sdaddr;
        lat_sstore <= sdstore;
        lat_vaddr  <= vdaddr;
        lat_vstore <= vdstore;
        lane_idx   <= first_idx;
      end
      if (acc_fetch) lat_iaddr <= iaddr;

      if ((state == SDATA) && xfer_done && !lat_write) sdload <= cLoad;

      if ((state == VDATA) && xfer_done) begin
        if (!lat_write) vdload[lane_idx] <= cLoad;
        if (!next_none) lane_idx <= next_idx;
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;
  import cpu_types_pkg::*;

  localparam int T = 4;

  logic CLK = 1'b0;
  logic RST;
  logic instReq, readReq, writeReq, isVector, dhalt, cWait;
  logic iHit, dHit, cREN, cWEN;
  word_t iaddr, sdaddr, sdstore, cLoad, iload, sdload, cAddr, cStore;
  logic [T-1:0] laneMask;
  logic [T-1:0][31:0] vdaddr, vdstore, vdload;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  lsu_sequencer #(.THREADS(T), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .instReq(instReq), .iaddr(iaddr), .iload(iload), .iHit(iHit),
    .readReq(readReq), .writeReq(writeReq), .isVector(isVector), .laneMask(laneMask),
    .sdaddr(sdaddr), .sdstore(sdstore), .vdaddr(vdaddr), .vdstore(vdstore),
    .sdload(sdload), .vdload(vdload), .dHit(dHit), .dhalt(dhalt),
    .cREN(cREN), .cWEN(cWEN), .cAddr(cAddr), .cStore(cStore),
    .cLoad(cLoad), .cWait(cWait)
  );

  // One expected cycle of the cache port / hit outputs, plus what the bench
  // drives on cWait/cLoad in that cycle.
  typedef struct {
    bit    ren;
    bit    wen;
    word_t addr;
    word_t store;
    word_t load;
    bit    cwait;
    bit    dhit;
    bit    ihit;
  } cyc_t;

  cyc_t  tl[$];
  word_t m_iload, m_sdload;
  word_t m_vdload[T];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_wait(input int wf);
    if (wf >= 0) return wf;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  function automatic cyc_t idle_cyc(input bit dh, input bit ih);
    cyc_t c;
    c.ren = 0; c.wen = 0; c.addr = '0; c.store = '0;
    c.load = $urandom; c.cwait = 1'($urandom_range(0, 1));
    c.dhit = dh; c.ihit = ih;
    return c;
  endfunction

  // One cache access: w stalled cycles followed by the completing cycle.
  task automatic add_access(input word_t addr, input bit we, input word_t st,
                            input int w, output word_t ld);
    cyc_t c;
    c.ren = !we; c.wen = we; c.addr = addr; c.store = st; c.dhit = 0; c.ihit = 0;
    for (int j = 0; j < w; j++) begin
      c.cwait = 1; c.load = $urandom;
      tl.push_back(c);
    end
    c.cwait = 0; c.load = $urandom; ld = c.load;
    tl.push_back(c);
  endtask

  // Builds the expected cycle timeline from the operation, then drives and checks it.
  task automatic run_op(input bit rd, input bit wr, input bit vec, input bit ir,
                        input logic [T-1:0] mask, input word_t sa, input word_t ss,
                        input word_t ia, input logic [T-1:0][31:0] va,
                        input logic [T-1:0][31:0] vs, input int wf);
    bit    data;
    word_t ld;
    data = rd | wr;
    tl.delete();
    if (data) begin
      if (!vec) begin
        add_access(sa, wr, ss, pick_wait(wf), ld);
        if (!wr) m_sdload = ld;
      end else begin
        for (int i = 0; i < T; i++) begin
          if (mask[i]) begin
            add_access(va[i], wr, vs[i], pick_wait(wf), ld);
            if (!wr) m_vdload[i] = ld;
          end
        end
      end
      tl.push_back(idle_cyc(1, 0));
    end
    if (ir) begin
      if (data) tl.push_back(idle_cyc(0, 0));
      add_access(ia, 0, '0, pick_wait(wf), ld);
      m_iload = ld;
      tl.push_back(idle_cyc(0, 1));
    end
    tl.push_back(idle_cyc(0, 0));
    tl.push_back(idle_cyc(0, 0));

    @(negedge CLK);
    readReq = rd; writeReq = wr; isVector = vec; laneMask = mask;
    sdaddr = sa; sdstore = ss; iaddr = ia; vdaddr = va; vdstore = vs; instReq = ir;
    cWait = 1'($urandom_range(0, 1)); cLoad = $urandom;

    foreach (tl[n]) begin
      @(negedge CLK);
      chk("cREN", 32'(cREN), 32'(tl[n].ren));
      chk("cWEN", 32'(cWEN), 32'(tl[n].wen));
      chk("dHit", 32'(dHit), 32'(tl[n].dhit));
      chk("iHit", 32'(iHit), 32'(tl[n].ihit));
      if (tl[n].ren || tl[n].wen) chk("cAddr", cAddr, tl[n].addr);
      if (tl[n].wen) chk("cStore", cStore, tl[n].store);
      if (n == 0) begin
        // Operands after acceptance must have no effect.
        readReq = 0; writeReq = 0;
        isVector = 1'($urandom_range(0, 1)); laneMask = 4'($urandom);
        sdaddr = $urandom; sdstore = $urandom;
        vdaddr = {$urandom, $urandom, $urandom, $urandom};
        vdstore = {$urandom, $urandom, $urandom, $urandom};
        if (!(ir && data)) iaddr = $urandom;
      end
      if (tl[n].ihit) instReq = 0;
      cWait = tl[n].cwait;
      cLoad = tl[n].load;
    end
    chk("sdload", sdload, m_sdload);
    chk("iload", iload, m_iload);
    for (int i = 0; i < T; i++) chk($sformatf("vdload%0d", i), vdload[i], m_vdload[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cREN"}, 32'(cREN), 0);
    chk({tag, "_cWEN"}, 32'(cWEN), 0);
    chk({tag, "_cAddr"}, cAddr, 0);
    chk({tag, "_cStore"}, cStore, 0);
    chk({tag, "_dHit"}, 32'(dHit), 0);
    chk({tag, "_iHit"}, 32'(iHit), 0);
    chk({tag, "_iload"}, iload, 0);
    chk({tag, "_sdload"}, sdload, 0);
    for (int i = 0; i < T; i++) chk($sformatf("%s_vdload%0d", tag, i), vdload[i], 0);
  endtask

  initial begin
    bit rd, wr, vec, ir;
    int kind;
    RST = 0;
    instReq = 0; readReq = 0; writeReq = 0; isVector = 0; dhalt = 0; cWait = 0;
    iaddr = 0; sdaddr = 0; sdstore = 0; cLoad = 0; laneMask = 0; vdaddr = '0; vdstore = '0;
    m_iload = 0; m_sdload = 0;
    for (int i = 0; i < T; i++) m_vdload[i] = 0;
    #1 RST = 1;
    #11;
    check_reset_outputs("rst");
    @(negedge CLK);
    RST = 0;

    // Scalar load at 0x100, no stalls.
    run_op(1, 0, 0, 0, '0, 32'h100, 0, 0, '0, '0, 0);
    // Vector store, lanes 1 and 3 only.
    run_op(0, 1, 1, 0, 4'b1010, 0, 0, 0, {32'hC, 32'h8, 32'h4, 32'h0},
           {32'h33, 32'h22, 32'h11, 32'h00}, 0);
    // Vector load with an empty mask: no strobes, vdload untouched.
    run_op(1, 0, 1, 0, 4'b0000, 0, 0, 0, {32'h1, 32'h2, 32'h3, 32'h4}, '0, 0);
    // Data and fetch together, three stall cycles on every access.
    run_op(1, 0, 0, 1, '0, 32'h200, 0, 32'h400, '0, '0, 3);

    // Halted: a request is never accepted.
    @(negedge CLK);
    dhalt = 1; readReq = 1; sdaddr = 32'h500;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      chk("halt_cREN", 32'(cREN), 0);
      chk("halt_cWEN", 32'(cWEN), 0);
      chk("halt_dHit", 32'(dHit), 0);
    end
    readReq = 0; dhalt = 0;
    chk("halt_sdload", sdload, m_sdload);

    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(0, 5);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      vec = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      ir = (kind == 5);
      if (kind == 4) begin rd = 0; wr = 0; ir = 1; end
      run_op(rd, wr, vec, ir, 4'($urandom), $urandom, $urandom, $urandom,
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, -1);
    end

    // Reset in the middle of a vector load, while lane 2 is on the port.
    @(negedge CLK);
    cWait = 0;
    readReq = 1; isVector = 1; laneMask = 4'hF;
    vdaddr = {32'h3C, 32'h38, 32'h34, 32'h30};
    @(negedge CLK);
    readReq = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("lane2_cAddr", cAddr, 32'h38);
    #2 RST = 1;
    #1;
    check_reset_outputs("midrst");
    m_iload = 0; m_sdload = 0;
    for (int i = 0; i < T; i++) m_vdload[i] = 0;
    @(negedge CLK);
    RST = 0;
    run_op(1, 0, 0, 0, '0, 32'h600, 0, 0, '0, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter: THREADS, 4, number of vector lanes.
REQ-002 Parameter: PC_INIT-independent; WORD_W, 32, data/address width.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 instReq  in  1  datapath requests instruction fetch.
REQ-006 iaddr  in  WORD_W  fetch address.
REQ-007 iload  out  WORD_W  registered fetched instruction.
REQ-008 iHit  out  1  one-cycle pulse: iload valid.
REQ-009 readReq / writeReq  in  1 each  data load / store request.
REQ-010 isVector  in  1  request is per-lane vector access.
REQ-011 laneMask  in  THREADS  active lanes for vector access.
REQ-012 sdaddr / sdstore  in  WORD_W each  scalar address / store data.
REQ-013 vdaddr / vdstore  in  THREADS x WORD_W each  per-lane address / store data.
REQ-014 sdload  out  WORD_W; vdload  out  THREADS x WORD_W  registered load data.
REQ-015 dHit  out  1  one-cycle pulse: data operation complete.
REQ-016 dhalt  in  1  processor halted; blocks new acceptance.
REQ-017 cREN / cWEN  out  1 each; cAddr / cStore  out  WORD_W  single shared cache port.
REQ-018 cLoad  in  WORD_W; cWait  in  1  access completes in any cycle cREN|cWEN high and cWait low.

Function
REQ-019 FSM states IDLE, IFETCH, SDATA, VDATA, DONE.
REQ-020 IDLE, dhalt low, readReq|writeReq: latch addresses, store data, mask, isVector, direction; go SDATA (scalar) or VDATA (vector, lane = lowest set mask bit); mask all-zero goes directly DONE.
REQ-021 IDLE, no data request, instReq: latch iaddr, go IFETCH; data always wins over fetch in the same cycle.
REQ-022 readReq and writeReq both high: treated as store; read ignored.
REQ-023 IFETCH: cREN=1, cAddr=latched iaddr; on completion iload<=cLoad, iHit pulses next cycle, return IDLE.
REQ-024 SDATA: cREN or cWEN per direction, cAddr/cStore from latched scalar values; on completion load captures sdload, go DONE.
REQ-025 VDATA: access lane idx; on completion load captures vdload[idx]; advance to next higher set mask bit, after highest go DONE; lanes ascend, masked lanes never accessed, their vdload retained.
REQ-026 DONE: dHit=1 exactly one cycle, return IDLE.
REQ-027 cREN/cWEN low in IDLE and DONE; never both high.
REQ-028 cWait high: hold cAddr, cStore, strobes, lane index unchanged.
REQ-029 Latency with cWait=0: scalar dHit 2 cycles after accept; vector with k active lanes k+1 cycles; zero lanes 1 cycle; fetch iHit 2 cycles.
REQ-030 dhalt high: no new acceptance; in-flight operation completes normally.
REQ-031 Request inputs sampled only at acceptance; changes afterwards ignored.

Reset
REQ-032 RST high: state IDLE, cREN=cWEN=0, cAddr=cStore=0, iHit=dHit=0, iload=sdload=0, all vdload=0, lane index 0, immediately and asynchronously, including mid-operation; aborted access not retried.

Structure
REQ-033 lsu_state_t enum and THREADS default reside in cpu_types_pkg; word_t reused.
REQ-034 Sub-module lane_priority_enc: given mask and current index, returns next set lane above index plus none-left flag.

Verification
REQ-035 Scalar load, sdaddr=0x100, cLoad=0xDEADBEEF, cWait=0 -> cREN one cycle at 0x100, sdload=0xDEADBEEF, dHit 2 cycles after accept.
REQ-036 Vector store, mask=4'b1010, vdaddr={0x0,0x4,0x8,0xC} -> cWEN at 0x4 then 0xC only, dHit cycle 3.
REQ-037 Vector load, mask=4'b0000 -> no cache strobe, dHit 1 cycle after accept, vdload unchanged.
REQ-038 readReq and instReq same cycle, cWait high 3 cycles -> data first with address held stable, then fetch; iHit after dHit.
REQ-039 RST asserted mid-VDATA lane 2 -> strobes drop same cycle, outputs zero, next request restarts from IDLE.
REQ-040 dhalt=1 with readReq -> no acceptance, no strobes, no dHit.
